// File: rtl/noc_initiator_if.sv
// Local request/response port and NoC byte bus of the host-side initiator.
// The master modport is the initiator's view; the slave modport is the requester plus device side.
interface noc_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_len;
    logic [3:0]  req_dest;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        CmdW;
    logic [7:0]  DataW;
    logic        CmdR;
    logic [7:0]  DataR;
    logic        rsp_valid;
    logic        rsp_write;
    logic        rsp_err;
    logic [63:0] rsp_rdata;

    modport master (
        input  req_valid, req_write, req_len, req_dest, req_addr, req_wdata, CmdR, DataR,
        output req_ready, CmdW, DataW, rsp_valid, rsp_write, rsp_err, rsp_rdata
    );

    modport slave (
        output req_valid, req_write, req_len, req_dest, req_addr, req_wdata, CmdR, DataR,
        input  req_ready, CmdW, DataW, rsp_valid, rsp_write, rsp_err, rsp_rdata
    );
endinterface

// File: rtl/noc_initiator.sv
// Host-side NoC initiator: serializes one read/write request into a byte packet,
// then parses the matching response (or times out) and reports completion.
module noc_initiator #(
    parameter logic [3:0]  SRC_ID  = 4'h1,
    parameter int unsigned TIMEOUT = 1024
) (
    input logic             clk,
    input logic             rst,
    noc_initiator_if.master bus
);
    localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [2:0]    OP_RD_REQ = 3'b001;
    localparam logic [2:0]    OP_WR_REQ = 3'b010;
    localparam logic [2:0]    OP_RD_RSP = 3'b011;
    localparam logic [2:0]    OP_WR_RSP = 3'b100;

    typedef enum logic [2:0] {IDLE, CMD, ID, ADDR, WDATA, WAIT} txState_e;
    typedef enum logic [1:0] {R_IDLE, R_ID, R_DATA} rxState_e;

    txState_e      txState, txStateNext;
    rxState_e      rxState, rxStateNext;
    logic [2:0]    idx, idxNext;
    logic [TW-1:0] tmoCnt, tmoCntNext;
    logic          curWrite, curWriteNext;
    logic [1:0]    curLen, curLenNext;
    logic [3:0]    curDest, curDestNext;
    logic [31:0]   curAddr, curAddrNext;
    logic [63:0]   curWdata, curWdataNext;
    logic          rxIsWr, rxIsWrNext;
    logic [1:0]    rxLen, rxLenNext;
    logic [63:0]   rdAcc, rdAccNext;
    logic          cmdW, cmdWNext;
    logic [7:0]    dataW, dataWNext;
    logic          reqReady, reqReadyNext;
    logic          rspValid, rspValidNext;
    logic          rspWrite, rspWriteNext;
    logic          rspErr, rspErrNext;
    logic [63:0]   rspRdata, rspRdataNext;

    logic [2:0]    lastIdx;
    logic [2:0]    idxInc;
    logic [63:0]   rdMerged;
    logic          enterWait;
    logic          done;
    logic          doneErr;
    logic [63:0]   doneData;

    assign bus.req_ready = reqReady;
    assign bus.CmdW      = cmdW;
    assign bus.DataW     = dataW;
    assign bus.rsp_valid = rspValid;
    assign bus.rsp_write = rspWrite;
    assign bus.rsp_err   = rspErr;
    assign bus.rsp_rdata = rspRdata;

    // Index of the final payload byte for the captured length code
    always_comb begin
        case (curLen)
            2'd0:    lastIdx = 3'd0;
            2'd1:    lastIdx = 3'd1;
            2'd2:    lastIdx = 3'd3;
            default: lastIdx = 3'd7;
        endcase
    end

    always_comb begin
        txStateNext  = txState;
        rxStateNext  = rxState;
        idxNext      = idx;
        tmoCntNext   = tmoCnt;
        curWriteNext = curWrite;
        curLenNext   = curLen;
        curDestNext  = curDest;
        curAddrNext  = curAddr;
        curWdataNext = curWdata;
        rxIsWrNext   = rxIsWr;
        rxLenNext    = rxLen;
        rdAccNext    = rdAcc;
        cmdWNext     = cmdW;
        dataWNext    = dataW;
        reqReadyNext = reqReady;
        rspValidNext = 1'b0;
        rspWriteNext = rspWrite;
        rspErrNext   = rspErr;
        rspRdataNext = rspRdata;
        enterWait    = 1'b0;
        done         = 1'b0;
        doneErr      = 1'b0;
        doneData     = '0;
        idxInc       = idx + 3'd1;
        rdMerged     = rdAcc | (64'(bus.DataR) << {idx, 3'b000});

        case (txState)
            IDLE: begin
                reqReadyNext = 1'b1;
                if (bus.req_valid && reqReady) begin
                    curWriteNext = bus.req_write;
                    curLenNext   = bus.req_len;
                    curDestNext  = bus.req_dest;
                    curAddrNext  = bus.req_addr;
                    curWdataNext = bus.req_wdata;
                    cmdWNext     = 1'b1;
                    dataWNext    = {bus.req_write ? OP_WR_REQ : OP_RD_REQ, 3'b000, bus.req_len};
                    reqReadyNext = 1'b0;
                    txStateNext  = CMD;
                end
            end
            CMD: begin
                cmdWNext    = 1'b0;
                dataWNext   = {curDest, SRC_ID};
                txStateNext = ID;
            end
            ID: begin
                dataWNext   = curAddr[7:0];
                idxNext     = 3'd0;
                txStateNext = ADDR;
            end
            ADDR: begin
                if (idx == 3'd3) begin
                    if (curWrite) begin
                        dataWNext   = curWdata[7:0];
                        idxNext     = 3'd0;
                        txStateNext = WDATA;
                    end else begin
                        enterWait = 1'b1;
                    end
                end else begin
                    idxNext   = idxInc;
                    dataWNext = 8'(curAddr >> {idxInc, 3'b000});
                end
            end
            WDATA: begin
                if (idx == lastIdx) begin
                    enterWait = 1'b1;
                end else begin
                    idxNext   = idxInc;
                    dataWNext = 8'(curWdata >> {idxInc, 3'b000});
                end
            end
            WAIT: begin
                tmoCntNext = tmoCnt + TW'(1);
                case (rxState)
                    R_IDLE: begin
                        if (bus.CmdR && (bus.DataR[7:5] == OP_RD_RSP || bus.DataR[7:5] == OP_WR_RSP)) begin
                            rxIsWrNext  = (bus.DataR[7:5] == OP_WR_RSP);
                            rxLenNext   = bus.DataR[1:0];
                            rxStateNext = R_ID;
                        end
                    end
                    R_ID: begin
                        if (bus.CmdR) begin
                            done    = 1'b1;
                            doneErr = 1'b1;
                        end else if (bus.DataR[7:4] != SRC_ID) begin
                            rxStateNext = R_IDLE;
                        end else if (rxIsWr != curWrite || (!curWrite && rxLen != curLen)) begin
                            done    = 1'b1;
                            doneErr = 1'b1;
                        end else if (curWrite) begin
                            done = 1'b1;
                        end else begin
                            idxNext     = 3'd0;
                            rxStateNext = R_DATA;
                        end
                    end
                    R_DATA: begin
                        if (bus.CmdR) begin
                            done    = 1'b1;
                            doneErr = 1'b1;
                        end else begin
                            rdAccNext = rdMerged;
                            if (idx == lastIdx) begin
                                done     = 1'b1;
                                doneData = rdMerged;
                            end else begin
                                idxNext = idxInc;
                            end
                        end
                    end
                    default: rxStateNext = R_IDLE;
                endcase

                // A real completion wins over a timeout in the same cycle
                if (!done && tmoCnt == TMO_LAST) begin
                    done    = 1'b1;
                    doneErr = 1'b1;
                end

                if (done) begin
                    rspValidNext = 1'b1;
                    rspWriteNext = curWrite;
                    rspErrNext   = doneErr;
                    rspRdataNext = doneErr ? 64'd0 : doneData;
                    reqReadyNext = 1'b1;
                    txStateNext  = IDLE;
                    rxStateNext  = R_IDLE;
                end
            end
            default: txStateNext = IDLE;
        endcase

        // Last request byte sent: idle the bus and arm the response parser
        if (enterWait) begin
            cmdWNext    = 1'b1;
            dataWNext   = 8'h00;
            txStateNext = WAIT;
            rxStateNext = R_IDLE;
            tmoCntNext  = '0;
            rdAccNext   = '0;
            idxNext     = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            txState  <= IDLE;
            rxState  <= R_IDLE;
            idx      <= 3'd0;
            tmoCnt   <= '0;
            curWrite <= 1'b0;
            curLen   <= 2'd0;
            curDest  <= 4'd0;
            curAddr  <= 32'd0;
            curWdata <= 64'd0;
            rxIsWr   <= 1'b0;
            rxLen    <= 2'd0;
            rdAcc    <= 64'd0;
            cmdW     <= 1'b1;
            dataW    <= 8'h00;
            reqReady <= 1'b0;
            rspValid <= 1'b0;
            rspWrite <= 1'b0;
            rspErr   <= 1'b0;
            rspRdata <= 64'd0;
        end else begin
            txState  <= txStateNext;
            rxState  <= rxStateNext;
            idx      <= idxNext;
            tmoCnt   <= tmoCntNext;
            curWrite <= curWriteNext;
            curLen   <= curLenNext;
            curDest  <= curDestNext;
            curAddr  <= curAddrNext;
            curWdata <= curWdataNext;
            rxIsWr   <= rxIsWrNext;
            rxLen    <= rxLenNext;
            rdAcc    <= rdAccNext;
            cmdW     <= cmdWNext;
            dataW    <= dataWNext;
            reqReady <= reqReadyNext;
            rspValid <= rspValidNext;
            rspWrite <= rspWriteNext;
            rspErr   <= rspErrNext;
            rspRdata <= rspRdataNext;
        end
    end
endmodule

// File: tb/tb_noc_initiator.sv
// Directed bench for noc_initiator: expected bus bytes and completions are queued
// as each request is issued, then popped and compared as the DUT produces them.
module tb_noc_initiator;
    localparam logic [3:0]  SRC = 4'h1;
    localparam int unsigned TMO = 1024;

    typedef struct packed {
        logic       cmd;
        logic [7:0] data;
    } busByte_t;

    typedef struct packed {
        logic        write;
        logic        err;
        logic [63:0] rdata;
        logic        chkData;
    } rspExp_t;

    logic     clk;
    logic     rst;
    int       checks   = 0;
    int       failures = 0;
    int       seen;
    busByte_t txQ[$];
    rspExp_t  rspQ[$];
    busByte_t eb;

    noc_initiator_if bus();

    noc_initiator #(.SRC_ID(SRC), .TIMEOUT(TMO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Queue the expected packet, then hand the request over on a valid/ready handshake
    task automatic issue(input logic wr, input logic [1:0] len, input logic [3:0] dest,
                         input logic [31:0] addr, input logic [63:0] wdata);
        int n;
        int waited;
        n = 1 << len;
        txQ.push_back({1'b1, wr ? 3'b010 : 3'b001, 3'b000, len});
        txQ.push_back({1'b0, dest, SRC});
        for (int i = 0; i < 4; i++) txQ.push_back({1'b0, addr[8*i +: 8]});
        if (wr) for (int i = 0; i < n; i++) txQ.push_back({1'b0, wdata[8*i +: 8]});
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_len   = len;
        bus.req_dest  = dest;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        waited = 0;
        while (!bus.req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("req_ready", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom());
        bus.req_len   = 2'($urandom());
        bus.req_dest  = 4'($urandom());
        bus.req_addr  = $urandom();
        bus.req_wdata = {$urandom(), $urandom()};
    endtask

    task automatic runTx();
        busByte_t e;
        while (txQ.size() > 0) begin
            e = txQ.pop_front();
            chk("tx_byte", 64'({bus.CmdW, bus.DataW}), 64'(e));
            @(negedge clk);
        end
        chk("tx_idle", 64'({bus.CmdW, bus.DataW}), 64'h100);
    endtask

    task automatic devSend(input logic c, input logic [7:0] d);
        bus.CmdR  = c;
        bus.DataR = d;
        @(negedge clk);
    endtask

    task automatic devIdle();
        bus.CmdR  = 1'b1;
        bus.DataR = 8'h00;
    endtask

    task automatic expectRsp();
        rspExp_t e;
        devIdle();
        chk("rsp_queue", 64'(rspQ.size() > 0), 64'd1);
        e = (rspQ.size() > 0) ? rspQ.pop_front() : '0;
        chk("rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("rsp_write", 64'(bus.rsp_write), 64'(e.write));
        chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
        if (e.chkData) chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        chk("ready_at_rsp", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        chk("rsp_pulse", 64'(bus.rsp_valid), 64'd0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_len   = 2'd0;
        bus.req_dest  = 4'd0;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 64'd0;
        devIdle();

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_bus", 64'({bus.CmdW, bus.DataW}), 64'h100);
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_write", 64'(bus.rsp_write), 64'd0);
        chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(bus.req_ready), 64'd1);

        // 4-byte read
        rspQ.push_back('{write: 1'b0, err: 1'b0, rdata: 64'h00000000DDCCBBAA, chkData: 1'b1});
        issue(1'b0, 2'd2, 4'h3, 32'h12345678, 64'd0);
        runTx();
        devSend(1'b1, 8'h62); devSend(1'b0, 8'h13);
        devSend(1'b0, 8'hAA); devSend(1'b0, 8'hBB); devSend(1'b0, 8'hCC); devSend(1'b0, 8'hDD);
        expectRsp();

        // 1-byte write
        rspQ.push_back('{write: 1'b1, err: 1'b0, rdata: 64'd0, chkData: 1'b1});
        issue(1'b1, 2'd0, 4'h2, 32'h0, 64'h5A);
        runTx();
        devSend(1'b1, 8'h80); devSend(1'b0, 8'h12);
        expectRsp();

        // 2-byte write
        rspQ.push_back('{write: 1'b1, err: 1'b0, rdata: 64'd0, chkData: 1'b1});
        issue(1'b1, 2'd1, 4'h5, 32'h00000010, 64'h1234);
        runTx();
        devSend(1'b1, 8'h80); devSend(1'b0, 8'h15);
        expectRsp();

        // Response addressed to another node is dropped, the next one completes
        rspQ.push_back('{write: 1'b0, err: 1'b0, rdata: 64'h77, chkData: 1'b1});
        issue(1'b0, 2'd0, 4'h2, 32'h00000100, 64'd0);
        runTx();
        devSend(1'b1, 8'h60); devSend(1'b0, 8'h23);
        chk("wrong_src_ignored", 64'(bus.rsp_valid), 64'd0);
        devSend(1'b1, 8'h00);
        devSend(1'b1, 8'h60); devSend(1'b0, 8'h12); devSend(1'b0, 8'h77);
        expectRsp();

        // No response: error completion exactly TMO cycles after WAIT entry
        rspQ.push_back('{write: 1'b0, err: 1'b1, rdata: 64'd0, chkData: 1'b1});
        issue(1'b0, 2'd1, 4'h4, 32'hA0B0C0D0, 64'd0);
        runTx();
        seen = 0;
        for (int k = 1; k <= int'(TMO) + 4; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                seen = k;
                break;
            end
        end
        chk("timeout_latency", 64'(seen), 64'(TMO));
        expectRsp();

        // Command byte in the middle of read data: truncated
        rspQ.push_back('{write: 1'b0, err: 1'b1, rdata: 64'd0, chkData: 1'b0});
        issue(1'b0, 2'd3, 4'h3, 32'h00000040, 64'd0);
        runTx();
        devSend(1'b1, 8'h63); devSend(1'b0, 8'h13);
        devSend(1'b0, 8'h01); devSend(1'b0, 8'h02); devSend(1'b0, 8'h03);
        devSend(1'b1, 8'h62);
        expectRsp();

        // Write response to a read
        rspQ.push_back('{write: 1'b0, err: 1'b1, rdata: 64'd0, chkData: 1'b1});
        issue(1'b0, 2'd0, 4'h3, 32'h00000008, 64'd0);
        runTx();
        devSend(1'b1, 8'h80); devSend(1'b0, 8'h13);
        expectRsp();

        // Read response with the wrong length code
        rspQ.push_back('{write: 1'b0, err: 1'b1, rdata: 64'd0, chkData: 1'b1});
        issue(1'b0, 2'd1, 4'h3, 32'h0000000C, 64'd0);
        runTx();
        devSend(1'b1, 8'h60); devSend(1'b0, 8'h13);
        expectRsp();

        // Reset during the address phase drops the request
        issue(1'b1, 2'd0, 4'h2, 32'hCAFE0000, 64'h5A);
        for (int i = 0; i < 3; i++) begin
            eb = txQ.pop_front();
            chk("pre_rst_byte", 64'({bus.CmdW, bus.DataW}), 64'(eb));
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_bus", 64'({bus.CmdW, bus.DataW}), 64'h100);
        chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        rst = 1'b0;
        txQ.delete();
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin
                bus.CmdR = 1'b1; bus.DataR = 8'h80;
            end else if (i == 1) begin
                bus.CmdR = 1'b0; bus.DataR = 8'h12;
            end else begin
                devIdle();
            end
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        chk("no_rsp_after_rst", 64'(seen), 64'd0);

        rspQ.push_back('{write: 1'b0, err: 1'b0, rdata: 64'hBEEF, chkData: 1'b1});
        issue(1'b0, 2'd1, 4'h3, 32'h00000055, 64'd0);
        runTx();
        devSend(1'b1, 8'h61); devSend(1'b0, 8'h13); devSend(1'b0, 8'hEF); devSend(1'b0, 8'hBE);
        expectRsp();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
